// File: rtl/dcpu_bus_pkg.sv
// Shared types and constants for the dcpu 16-bit cs/we/ack system bus.
// Used by bus_arbiter2 and bus_mux2.
package dcpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;

  // Read data returned to a master whose access was forced to complete.
  localparam logic [15:0] BUS_TIMEOUT_DAT = 16'hFFFF;

endpackage

// File: rtl/bus_mux2.sv
// Owner-select mux between two bus masters and the slave bus.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the non-owner always sees ack=0 and read data=0.
module bus_mux2
  import dcpu_bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
) (
  input  logic [1:0]    grant,
  input  logic          tmo,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdat,
  input  logic          m0_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdat,
  input  logic          m1_we,
  input  logic [DW-1:0] s_rdat,
  input  logic          s_ack,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdat,
  output logic          we,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdat,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdat
);

  logic [DW-1:0] rdat_sel;
  logic          ack_sel;

  // A forced completion overrides whatever the slave is presenting.
  assign rdat_sel = tmo ? DW'(BUS_TIMEOUT_DAT) : s_rdat;
  assign ack_sel  = s_ack | tmo;

  always_comb begin
    addr    = '0;
    wdat    = '0;
    we      = 1'b0;
    m0_ack  = 1'b0;
    m0_rdat = '0;
    m1_ack  = 1'b0;
    m1_rdat = '0;
    if (grant[0]) begin
      addr    = m0_addr;
      wdat    = m0_wdat;
      we      = m0_we;
      m0_ack  = ack_sel;
      m0_rdat = rdat_sel;
    end else if (grant[1]) begin
      addr    = m1_addr;
      wdat    = m1_wdat;
      we      = m1_we;
      m1_ack  = ack_sel;
      m1_rdat = rdat_sel;
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin two-master arbiter for the dcpu system bus; optional no-ack timeout via BUS_ARB_TIMEOUT_EN.
// Latency: a request seen at edge N drives o_cs in cycle N+1; one IDLE cycle follows every transaction.
// Backpressure: masters hold cs until ack; i_m0_hold blocks new m0 grants but never preempts one in flight.
module bus_arbiter2
  import dcpu_bus_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  output logic [DW-1:0] o_m0_dat,
  input  logic          i_m0_we,
  input  logic          i_m0_cs,
  output logic          o_m0_ack,
  input  logic          i_m0_hold,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  output logic [DW-1:0] o_m1_dat,
  input  logic          i_m1_we,
  input  logic          i_m1_cs,
  output logic          o_m1_ack,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_dat,
  input  logic [DW-1:0] i_dat,
  output logic          o_we,
  output logic          o_cs,
  input  logic          i_ack,
  output logic [1:0]    o_grant
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic          o_timeout
`endif
);

  arb_state_t state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic       own0, own1, owner_cs;
  logic       req0, req1;
  logic       tmo;

  assign req0     = i_m0_cs & ~i_m0_hold;
  assign req1     = i_m1_cs;
  assign own0     = (state == OWN0);
  assign own1     = (state == OWN1);
  assign owner_cs = (own0 & i_m0_cs) | (own1 & i_m1_cs);
  assign o_cs     = owner_cs;
  assign o_grant  = {own1, own0};

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // IDLE always precedes OWNx, so clearing there restarts the count per transaction.
  always_ff @(posedge i_clk) begin
    if (i_reset || state == IDLE) begin
      tmo_cnt <= 8'd0;
    end else if (!i_ack) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo       = owner_cs & ~i_ack & (tmo_cnt == 8'(TIMEOUT));
  assign o_timeout = tmo;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last_owner ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (i_ack || tmo) begin
          state_nxt      = IDLE;
          last_owner_nxt = 1'b0;
        end else if (!i_m0_cs) begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (i_ack || tmo) begin
          state_nxt      = IDLE;
          last_owner_nxt = 1'b1;
        end else if (!i_m1_cs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  bus_mux2 #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .grant   (o_grant),
    .tmo     (tmo),
    .m0_addr (i_m0_addr),
    .m0_wdat (i_m0_dat),
    .m0_we   (i_m0_we),
    .m1_addr (i_m1_addr),
    .m1_wdat (i_m1_dat),
    .m1_we   (i_m1_we),
    .s_rdat  (i_dat),
    .s_ack   (i_ack),
    .addr    (o_addr),
    .wdat    (o_dat),
    .we      (o_we),
    .m0_ack  (o_m0_ack),
    .m0_rdat (o_m0_dat),
    .m1_ack  (o_m1_ack),
    .m1_rdat (o_m1_dat)
  );

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: vector table, hand-written corner sequences, then random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_bus_arbiter2;

  localparam int TMO = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_m0_addr, i_m0_dat, o_m0_dat;
  logic        i_m0_we, i_m0_cs, o_m0_ack, i_m0_hold;
  logic [15:0] i_m1_addr, i_m1_dat, o_m1_dat;
  logic        i_m1_we, i_m1_cs, o_m1_ack;
  logic [15:0] o_addr, o_dat, i_dat;
  logic        o_we, o_cs, i_ack;
  logic [1:0]  o_grant;
  logic        tmo_obs;
`ifdef BUS_ARB_TIMEOUT_EN
  logic        o_timeout;
  assign tmo_obs = o_timeout;
`else
  assign tmo_obs = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  bus_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_m0_addr (i_m0_addr),
    .i_m0_dat  (i_m0_dat),
    .o_m0_dat  (o_m0_dat),
    .i_m0_we   (i_m0_we),
    .i_m0_cs   (i_m0_cs),
    .o_m0_ack  (o_m0_ack),
    .i_m0_hold (i_m0_hold),
    .i_m1_addr (i_m1_addr),
    .i_m1_dat  (i_m1_dat),
    .o_m1_dat  (o_m1_dat),
    .i_m1_we   (i_m1_we),
    .i_m1_cs   (i_m1_cs),
    .o_m1_ack  (o_m1_ack),
    .o_addr    (o_addr),
    .o_dat     (o_dat),
    .i_dat     (i_dat),
    .o_we      (o_we),
    .o_cs      (o_cs),
    .i_ack     (i_ack),
`ifdef BUS_ARB_TIMEOUT_EN
    .o_timeout (o_timeout),
`endif
    .o_grant   (o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic set_in(input logic m0cs, input logic hold, input logic m1cs, input logic ack);
    @(posedge i_clk);
    #1;
    i_m0_cs   = m0cs;
    i_m0_hold = hold;
    i_m1_cs   = m1cs;
    i_ack     = ack;
    #4;
  endtask

  task automatic fixed_bus();
    i_m0_addr = 16'h1234; i_m0_dat = 16'hA0A0; i_m0_we = 1'b0;
    i_m1_addr = 16'h5678; i_m1_dat = 16'hB1B1; i_m1_we = 1'b1;
    i_dat     = 16'hBEEF;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    i_m0_cs = 1'b1; i_m1_cs = 1'b1; i_ack = 1'b1; i_m0_hold = 1'b0;
    repeat (2) @(posedge i_clk);
    #4;
    check("reset grant", 64'(o_grant), 64'd0);
    check("reset cs/we", 64'({o_cs, o_we}), 64'd0);
    check("reset acks", 64'({o_m0_ack, o_m1_ack, tmo_obs}), 64'd0);
    check("reset bus", {o_addr, o_dat, o_m0_dat, o_m1_dat}, 64'd0);
    i_m0_cs = 1'b0; i_m1_cs = 1'b0; i_ack = 1'b0;
    i_reset = 1'b0;
  endtask

  typedef struct packed {
    logic       m0cs, hold, m1cs, ack;
    logic [1:0] grant;
    logic       cs, a0, a1;
  } vec_t;

  vec_t tbl[$];

  // Random-phase model state: owner -1 = idle.
  int          owner, last, own_cyc;
  logic        r_m0cs, r_hold, r_m1cs, r_ack, r_cs, r_tmo, r0, r1;
  logic [15:0] e_addr, e_dat, e_r0, e_r1, rd;
  logic        e_we;
  logic [1:0]  e_grant;

  initial begin
    i_reset = 1'b0;
    i_m0_cs = 1'b0; i_m1_cs = 1'b0; i_m0_hold = 1'b0; i_ack = 1'b0;
    fixed_bus();

    //                   m0 hd m1 ak grant  cs a0 a1
    // contention from reset: m0 first, strict alternation
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,2'b01,1'b1,1'b1,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,2'b10,1'b1,1'b0,1'b1});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,2'b01,1'b1,1'b1,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0});
    // single master, ack two cycles after o_cs rises
    tbl.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b0,1'b1,2'b01,1'b1,1'b1,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0});
    // hold: only m1 served, then m0 on release
    tbl.push_back(vec_t'{1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b1,1'b1,1'b1,2'b10,1'b1,1'b0,1'b1});
    tbl.push_back(vec_t'{1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b1,1'b1,1'b1,2'b10,1'b1,1'b0,1'b1});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,2'b01,1'b1,1'b1,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0});
    // hold raised mid-transaction does not preempt
    tbl.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b1,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,2'b01,1'b1,1'b1,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0});
    // m1 abort, late ack dropped
    tbl.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b1,1'b0,2'b10,1'b1,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0});
    // abort left last_owner=0, so m1 wins the next tie
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0});
    tbl.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,2'b10,1'b1,1'b0,1'b1});
    tbl.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0});

    do_reset();
    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      set_in(v.m0cs, v.hold, v.m1cs, v.ack);
      e_addr = (v.grant == 2'b01) ? 16'h1234 : (v.grant == 2'b10) ? 16'h5678 : 16'h0000;
      e_dat  = (v.grant == 2'b01) ? 16'hA0A0 : (v.grant == 2'b10) ? 16'hB1B1 : 16'h0000;
      e_we   = (v.grant == 2'b10);
      e_r0   = (v.grant == 2'b01) ? 16'hBEEF : 16'h0000;
      e_r1   = (v.grant == 2'b10) ? 16'hBEEF : 16'h0000;
      check($sformatf("row%0d grant", i), 64'(o_grant), 64'(v.grant));
      check($sformatf("row%0d cs", i), 64'(o_cs), 64'(v.cs));
      check($sformatf("row%0d acks", i), 64'({o_m0_ack, o_m1_ack, tmo_obs}), 64'({v.a0, v.a1, 1'b0}));
      check($sformatf("row%0d bus", i), 64'({o_addr, o_dat, o_we}), 64'({e_addr, e_dat, e_we}));
      check($sformatf("row%0d rdat", i), 64'({o_m0_dat, o_m1_dat}), 64'({e_r0, e_r1}));
    end

    // reset while m0 owns the bus: no ack ever reaches m0
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst own", 64'({o_grant, o_cs}), 64'({2'b01, 1'b1}));
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #4;
    check("midrst pre ack", 64'(o_m0_ack), 64'd0);
    @(posedge i_clk);
    #1;
    i_ack = 1'b1;
    #4;
    check("midrst idle", 64'({o_grant, o_cs}), 64'd0);
    check("midrst no ack", 64'({o_m0_ack, o_m1_ack}), 64'd0);
    i_reset = 1'b0; i_m0_cs = 1'b0; i_ack = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst after", 64'({o_grant, o_cs}), 64'd0);

`ifdef BUS_ARB_TIMEOUT_EN
    // slave never acks: forced completion on the 5th OWN cycle
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("tmo wait%0d", k), 64'({o_grant, o_m0_ack, o_timeout}), 64'({2'b01, 1'b0, 1'b0}));
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo fire", 64'({o_grant, o_m0_ack, o_m1_ack, o_timeout}), 64'({2'b01, 1'b1, 1'b0, 1'b1}));
    check("tmo rdat", 64'(o_m0_dat), 64'h0000_0000_0000_FFFF);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo idle", 64'({o_grant, o_timeout}), 64'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // randomized traffic against the rule model
    do_reset();
    owner = -1; last = 1; own_cyc = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge i_clk);
      #1;
      r_m0cs = ($urandom_range(3) != 0);
      r_hold = ($urandom_range(3) == 0);
      r_m1cs = ($urandom_range(3) != 0);
      r_cs   = (owner == 0) ? r_m0cs : (owner == 1) ? r_m1cs : 1'b0;
      r_ack  = r_cs && ($urandom_range(2) == 0);
`ifdef BUS_ARB_TIMEOUT_EN
      r_tmo  = r_cs && !r_ack && (own_cyc == TMO);
`else
      r_tmo  = 1'b0;
`endif
      i_m0_addr = 16'($urandom); i_m0_dat = 16'($urandom); i_m0_we = 1'($urandom);
      i_m1_addr = 16'($urandom); i_m1_dat = 16'($urandom); i_m1_we = 1'($urandom);
      i_dat     = 16'($urandom);
      i_m0_cs = r_m0cs; i_m0_hold = r_hold; i_m1_cs = r_m1cs; i_ack = r_ack;
      #4;
      rd      = r_tmo ? 16'hFFFF : i_dat;
      e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      e_addr  = (owner == 0) ? i_m0_addr : (owner == 1) ? i_m1_addr : 16'h0000;
      e_dat   = (owner == 0) ? i_m0_dat : (owner == 1) ? i_m1_dat : 16'h0000;
      e_we    = (owner == 0) ? i_m0_we : (owner == 1) ? i_m1_we : 1'b0;
      e_r0    = (owner == 0) ? rd : 16'h0000;
      e_r1    = (owner == 1) ? rd : 16'h0000;
      check($sformatf("rnd%0d ctl", n),
            64'({o_grant, o_cs, o_we, o_m0_ack, o_m1_ack, tmo_obs}),
            64'({e_grant, r_cs, e_we, (owner == 0) && (r_ack || r_tmo),
                 (owner == 1) && (r_ack || r_tmo), r_tmo}));
      check($sformatf("rnd%0d dat", n), {o_addr, o_dat, o_m0_dat, o_m1_dat}, {e_addr, e_dat, e_r0, e_r1});
      if (owner < 0) begin
        r0 = r_m0cs && !r_hold;
        r1 = r_m1cs;
        own_cyc = 0;
        if (r0 && r1) owner = (last == 0) ? 1 : 0;
        else if (r0) owner = 0;
        else if (r1) owner = 1;
      end else if (r_ack || r_tmo) begin
        last  = owner;
        owner = -1;
      end else if (!r_cs) begin
        owner = -1;
      end else begin
        own_cyc++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-master, one-slave arbiter for the 16-bit cs/we/ack system bus.
- Master 0 is the dcpu data port; master 1 is the UART master (debug loader) port, which is currently tied off.
- The arbiter owns the external memory bus: muxes address, data and we onto it, and routes ack and read data back to the granted master only.
- Round-robin fairness. Optional no-ack timeout guards against a hung slave.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, cycles without ack before a forced completion; 8-bit counter; only used with BUS_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_addr  in  AW  master 0 address.
- i_m0_dat  in  DW  master 0 write data.
- o_m0_dat  out  DW  master 0 read data.
- i_m0_we  in  1  master 0 write enable.
- i_m0_cs  in  1  master 0 request/select.
- o_m0_ack  out  1  master 0 completion pulse.
- i_m0_hold  in  1  high blocks new master 0 grants (debug halt).
- i_m1_addr, i_m1_dat, o_m1_dat, i_m1_we, i_m1_cs, o_m1_ack  as master 0, for master 1.
- o_addr  out  AW  slave address.
- o_dat  out  DW  slave write data.
- i_dat  in  DW  slave read data.
- o_we  out  1  slave write enable.
- o_cs  out  1  slave select.
- i_ack  in  1  slave completion, one-cycle pulse.
- o_grant  out  2  one-hot current owner; 00 means idle.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is i_reset, synchronous and active-high.
- Reset values:
  - state IDLE, o_grant=00, last_owner=1 (so master 0 wins the first tie).
  - o_cs=0, o_we=0, both acks 0, o_addr/o_dat/o_m0_dat/o_m1_dat = 0, timeout counter 0.
- Request qualification: req0 = i_m0_cs & ~i_m0_hold; req1 = i_m1_cs.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only one request -> go to that master's OWN state.
  - Both requested -> grant the master that is not last_owner.
  - No request -> stay.
  - Arbitration is registered: a request first seen at edge N drives o_cs at cycle N+1.
- OWN0 / OWN1:
  - o_cs is high; o_addr, o_dat and o_we are combinationally driven from the owner's inputs.
  - Owner ack = i_ack; owner read data = i_dat.
  - Non-owner ack = 0 and non-owner read data = 0 at all times.
  - On the cycle i_ack=1: next state IDLE, last_owner = owner.
  - If the owner drops cs before ack (abort): next state IDLE, o_cs falls that cycle, last_owner unchanged.
- Transaction framing:
  - Each access ends on ack. One mandatory IDLE cycle follows every transaction.
  - A master still holding cs in the IDLE cycle after its ack is treated as a new request.
  - Back-to-back contention therefore alternates strictly 0,1,0,1.
- i_m0_hold only gates new grants; it never preempts an OWN0 transaction in progress.
- i_ack received in IDLE is ignored and is not forwarded to either master.
- Reset mid-transaction: returns to IDLE next edge with o_cs=0; the aborted master receives no ack.
- o_grant reflects the state: OWN0 -> 01, OWN1 -> 10, IDLE -> 00.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering OWNx and increments each OWN cycle without i_ack.
  - When the counter equals TIMEOUT: owner ack=1, owner read data=16'hFFFF, next state IDLE, last_owner updated.
  - Port o_timeout (out, 1) pulses high for that one cycle; its reset value is 0.
- Undefined: no counter, no o_timeout port; an OWN state waits indefinitely for ack or cs drop.

Decomposition:
- Shared package dcpu_bus_pkg:
  - state enum (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - bus width constants;
  - timeout read-data constant 16'hFFFF.
- One sub-module is natural: bus_mux2, a purely combinational owner-select mux for addr/dat/we and ack/data return. The FSM and counter stay in bus_arbiter2.

Test Plan:
- Single master: m0 cs=1, addr=16'h1234, we=0; slave acks 2 cycles after o_cs with i_dat=16'hBEEF -> o_cs high one cycle after m0 cs; o_m0_dat=16'hBEEF with o_m0_ack; o_m1_ack stays 0.
- Contention from reset: m0 and m1 both cs=1 at the same edge, slave always acks after 1 cycle -> grants alternate 01,00,10,00,01, starting with m0.
- Hold: i_m0_hold=1, m0 and m1 requesting -> only m1 is granted, repeatedly; drop hold -> m0 granted on the next arbitration.
- Abort: m1 granted, m1 drops cs before ack -> o_cs falls the same cycle, IDLE next edge, a late i_ack is not forwarded.
- Reset mid-transaction: i_reset=1 while in OWN0 -> next edge o_cs=0, o_grant=00, no o_m0_ack pulse.
- Timeout (with BUS_ARB_TIMEOUT_EN, TIMEOUT=4): slave never acks -> o_m0_ack and o_timeout pulse on the 5th OWN cycle with o_m0_dat=16'hFFFF, then IDLE.
